// File: rtl/mag_pkg.sv
// mag_pkg -- shared constants for the gradient magnitude scheduler.
//   Default widths for pixels, magnitude and tan, the fixed tan fraction
//   width, and the requester-id encoding used on m_id and for arbitration.
package mag_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int MAG_I_DEF = 9;
  localparam int MAG_F_DEF = 16;
  localparam int TAN_W_DEF = 19;
  localparam int CNT_W_DEF = 16;

  // m_tan always carries 16 fraction bits, whatever TAN_W is.
  localparam int TAN_F = 16;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/mag_cal.sv
// mag_cal -- combinational gradient calculator.
//   i_pixel     : {top, bottom, left, right}, PIX_W bits each, unsigned
//   o_magnitude : floor(sqrt(dx^2 + dy^2)) with MAG_F fraction bits
//   o_tan       : |dy| / |dx| with TAN_F fraction bits, truncated;
//                 saturates to all ones when |dx| == 0 or on overflow
//   o_negative  : dx and dy have opposite signs (dx = right - left,
//                 dy = bottom - top; zero counts as non-negative)
// The radicand is (dx^2+dy^2) << 2*MAG_F, which must fit in 2*(MAG_I+MAG_F)
// bits; with the defaults it needs 49 of the 50 available.
module mag_cal
  import mag_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int MAG_I = MAG_I_DEF,
  parameter int MAG_F = MAG_F_DEF,
  parameter int TAN_W = TAN_W_DEF
) (
  input  logic [4*PIX_W-1:0]     i_pixel,
  output logic [MAG_I+MAG_F-1:0] o_magnitude,
  output logic [TAN_W-1:0]       o_tan,
  output logic                   o_negative
);

  localparam int MAG_W = MAG_I + MAG_F;
  localparam int SQ_W  = 2 * PIX_W + 1;
  localparam int RAD_W = 2 * MAG_W;
  localparam int NUM_W = PIX_W + TAN_F;

  logic [PIX_W-1:0] w_top, w_bot, w_left, w_right;
  logic [PIX_W-1:0] w_abs_dx, w_abs_dy;
  logic             w_dx_neg, w_dy_neg;
  logic [SQ_W-1:0]  w_sum;
  logic [RAD_W-1:0] w_rad;
  logic [NUM_W-1:0] w_num;

  assign w_top   = i_pixel[4*PIX_W-1 -: PIX_W];
  assign w_bot   = i_pixel[3*PIX_W-1 -: PIX_W];
  assign w_left  = i_pixel[2*PIX_W-1 -: PIX_W];
  assign w_right = i_pixel[PIX_W-1:0];

  assign w_dx_neg = (w_right < w_left);
  assign w_dy_neg = (w_bot < w_top);
  assign w_abs_dx = w_dx_neg ? (w_left - w_right) : (w_right - w_left);
  assign w_abs_dy = w_dy_neg ? (w_top - w_bot)    : (w_bot - w_top);

  assign w_sum = SQ_W'(w_abs_dx) * SQ_W'(w_abs_dx)
               + SQ_W'(w_abs_dy) * SQ_W'(w_abs_dy);
  assign w_rad = RAD_W'(w_sum) << (2 * MAG_F);
  assign w_num = {w_abs_dy, {TAN_F{1'b0}}};

  // Digit-by-digit square root: one result bit per radicand bit pair.
  logic [MAG_W+1:0] w_sq_rem;
  logic [MAG_W+1:0] w_sq_trial;
  logic [MAG_W-1:0] w_sq_root;

  always_comb begin
    w_sq_rem   = '0;
    w_sq_trial = '0;
    w_sq_root  = '0;
    for (int i = MAG_W - 1; i >= 0; i--) begin
      w_sq_rem   = {w_sq_rem[MAG_W-1:0], w_rad[2*i +: 2]};
      w_sq_trial = {w_sq_root, 2'b01};
      if (w_sq_rem >= w_sq_trial) begin
        w_sq_rem  = w_sq_rem - w_sq_trial;
        w_sq_root = {w_sq_root[MAG_W-2:0], 1'b1};
      end else begin
        w_sq_root = {w_sq_root[MAG_W-2:0], 1'b0};
      end
    end
  end

  // Restoring division of |dy| << TAN_F by |dx|.
  logic [PIX_W:0]   w_div_rem;
  logic [NUM_W-1:0] w_div_q;

  always_comb begin
    w_div_rem = '0;
    w_div_q   = '0;
    for (int i = NUM_W - 1; i >= 0; i--) begin
      w_div_rem = {w_div_rem[PIX_W-1:0], w_num[i]};
      if (w_div_rem >= {1'b0, w_abs_dx}) begin
        w_div_rem  = w_div_rem - {1'b0, w_abs_dx};
        w_div_q[i] = 1'b1;
      end
    end
  end

  assign o_magnitude = w_sq_root;
  assign o_tan       = ((w_abs_dx == '0) || ((w_div_q >> TAN_W) != '0))
                     ? '1 : TAN_W'(w_div_q);
  assign o_negative  = w_dx_neg ^ w_dy_neg;

endmodule

// File: rtl/mag_sched.sv
// mag_sched -- two requesters sharing one mag_cal through a 2-stage pipeline.
//   s0_* / s1_* : valid/ready requester ports, pixel = {top,bottom,left,right}
//   m_*         : result port (magnitude, tan, sign flag, owning requester id)
//   done0/done1 : wrapping count of results delivered to each requester
// Stage A holds the granted tuple feeding mag_cal; stage B registers the
// mag_cal result and drives m_*. Round-robin arbitration favours the
// requester that was not granted last; last_id resets to 1 so requester 0
// wins the first contention.
module mag_sched
  import mag_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int MAG_I = MAG_I_DEF,
  parameter int MAG_F = MAG_F_DEF,
  parameter int TAN_W = TAN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s0_valid,
  output logic                   s0_ready,
  input  logic [4*PIX_W-1:0]     s0_pixel,
  input  logic                   s1_valid,
  output logic                   s1_ready,
  input  logic [4*PIX_W-1:0]     s1_pixel,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [MAG_I+MAG_F-1:0] m_magnitude,
  output logic [TAN_W-1:0]       m_tan,
  output logic                   m_negative,
  output logic                   m_id,
  output logic [CNT_W-1:0]       done0,
  output logic [CNT_W-1:0]       done1
);

  localparam int MAG_W = MAG_I + MAG_F;

  logic               r_a_valid;
  logic [4*PIX_W-1:0] r_a_pix;
  logic               r_a_id;
  logic               r_b_valid;
  logic [MAG_W-1:0]   r_b_mag;
  logic [TAN_W-1:0]   r_b_tan;
  logic               r_b_neg;
  logic               r_b_id;
  logic               r_last_id;
  logic [CNT_W-1:0]   r_done0;
  logic [CNT_W-1:0]   r_done1;

  logic             w_grant0, w_grant1;
  logic             w_acc0, w_acc1;
  logic             w_a_advance, w_b_load, w_out_xfer;
  logic [MAG_W-1:0] w_cal_mag;
  logic [TAN_W-1:0] w_cal_tan;
  logic             w_cal_neg;

  // Stage B can take stage A's tuple when it is empty or draining this
  // cycle; stage A can take a new tuple when it is empty or moving on.
  assign w_b_load    = r_a_valid && (!r_b_valid || m_ready);
  assign w_a_advance = !r_a_valid || w_b_load;
  assign w_out_xfer  = r_b_valid && m_ready;

  assign w_grant0 = s0_valid && (!s1_valid || (r_last_id == ID_REQ1));
  assign w_grant1 = s1_valid && (!s0_valid || (r_last_id == ID_REQ0));

  assign s0_ready = w_grant0 && w_a_advance;
  assign s1_ready = w_grant1 && w_a_advance;
  assign w_acc0   = s0_valid && s0_ready;
  assign w_acc1   = s1_valid && s1_ready;

  mag_cal #(
    .PIX_W(PIX_W),
    .MAG_I(MAG_I),
    .MAG_F(MAG_F),
    .TAN_W(TAN_W)
  ) u_mag_cal (
    .i_pixel    (r_a_pix),
    .o_magnitude(w_cal_mag),
    .o_tan      (w_cal_tan),
    .o_negative (w_cal_neg)
  );

  // Stage A and arbitration state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_pix   <= '0;
      r_a_id    <= ID_REQ0;
      r_last_id <= ID_REQ1;
    end else begin
      if (w_a_advance) begin
        r_a_valid <= w_acc0 || w_acc1;
        if (w_acc0) begin
          r_a_pix <= s0_pixel;
          r_a_id  <= ID_REQ0;
        end else if (w_acc1) begin
          r_a_pix <= s1_pixel;
          r_a_id  <= ID_REQ1;
        end
      end
      if (w_acc0) begin
        r_last_id <= ID_REQ0;
      end else if (w_acc1) begin
        r_last_id <= ID_REQ1;
      end
    end
  end

  // Stage B: loads whenever stage A moves on, otherwise empties on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b_valid <= 1'b0;
      r_b_mag   <= '0;
      r_b_tan   <= '0;
      r_b_neg   <= 1'b0;
      r_b_id    <= ID_REQ0;
    end else if (w_b_load) begin
      r_b_valid <= 1'b1;
      r_b_mag   <= w_cal_mag;
      r_b_tan   <= w_cal_tan;
      r_b_neg   <= w_cal_neg;
      r_b_id    <= r_a_id;
    end else if (w_out_xfer) begin
      r_b_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done0 <= '0;
      r_done1 <= '0;
    end else if (w_out_xfer) begin
      if (r_b_id == ID_REQ0) begin
        r_done0 <= r_done0 + CNT_W'(1);
      end else begin
        r_done1 <= r_done1 + CNT_W'(1);
      end
    end
  end

  assign m_valid     = r_b_valid;
  assign m_magnitude = r_b_mag;
  assign m_tan       = r_b_tan;
  assign m_negative  = r_b_neg;
  assign m_id        = r_b_id;
  assign done0       = r_done0;
  assign done1       = r_done1;

endmodule

// File: tb/tb_mag_sched.sv
// tb_mag_sched -- self-checking bench for mag_sched.
// A negedge monitor logs accepted tuples and delivered results; each test
// task compares them against a behavioural model (real-valued sqrt, integer
// divide, round-robin rule) and checks scenario-specific conditions inline.
module tb_mag_sched;

  localparam int PIX_W = 8;
  localparam int MAG_I = 9;
  localparam int MAG_F = 16;
  localparam int TAN_W = 19;
  localparam int CNT_W = 4;
  localparam int MAG_W = MAG_I + MAG_F;
  localparam int CNT_M = 1 << CNT_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 s0_valid = 1'b0, s1_valid = 1'b0;
  logic                 s0_ready, s1_ready;
  logic [4*PIX_W-1:0]   s0_pixel = '0, s1_pixel = '0;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic [MAG_W-1:0]     m_magnitude;
  logic [TAN_W-1:0]     m_tan;
  logic                 m_negative;
  logic                 m_id;
  logic [CNT_W-1:0]     done0, done1;

  always #5 clk = ~clk;

  mag_sched #(
    .PIX_W(PIX_W), .MAG_I(MAG_I), .MAG_F(MAG_F), .TAN_W(TAN_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_pixel(s0_pixel),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_pixel(s1_pixel),
    .m_valid(m_valid), .m_ready(m_ready), .m_magnitude(m_magnitude),
    .m_tan(m_tan), .m_negative(m_negative), .m_id(m_id),
    .done0(done0), .done1(done1)
  );

  typedef struct {
    logic               id;
    logic [4*PIX_W-1:0] pix;
    logic               contend;
  } acc_t;

  typedef struct {
    logic             id;
    logic [MAG_W-1:0] mag;
    logic [TAN_W-1:0] tan;
    logic             neg;
  } out_t;

  acc_t acc_q[$];
  out_t out_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   acc0_flag, acc1_flag;
  logic model_last = 1'b1;
  int   md0 = 0, md1 = 0;

  // ---------------- behavioural reference model ----------------
  function automatic int fld(input logic [31:0] p, input int k);
    logic [7:0] b;
    b = p[k*8 +: 8];
    return int'(b);
  endfunction

  function automatic real exp_mag(input logic [31:0] p);
    int dx, dy;
    dx = fld(p, 0) - fld(p, 1);
    dy = fld(p, 2) - fld(p, 3);
    return $sqrt(real'(dx * dx + dy * dy)) * 65536.0;
  endfunction

  function automatic logic [TAN_W-1:0] exp_tan(input logic [31:0] p);
    int adx, ady, q;
    adx = fld(p, 0) - fld(p, 1);
    ady = fld(p, 2) - fld(p, 3);
    if (adx < 0) adx = -adx;
    if (ady < 0) ady = -ady;
    if (adx == 0) return '1;
    q = (ady * 65536) / adx;
    if (q > (1 << TAN_W) - 1) return '1;
    return TAN_W'(q);
  endfunction

  function automatic logic exp_neg(input logic [31:0] p);
    return (fld(p, 0) < fld(p, 1)) != (fld(p, 2) < fld(p, 3));
  endfunction

  function automatic logic [31:0] pack(input int t, input int b, input int l, input int r);
    return {8'(t), 8'(b), 8'(l), 8'(r)};
  endfunction

  function automatic logic [31:0] rand_pix();
    logic [31:0] p;
    p = $urandom;
    if ($urandom_range(0, 7) == 0) p[15:8] = p[7:0];
    return p;
  endfunction

  // ---------------- monitor (logging only) ----------------
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    acc0_flag = 1'b0;
    acc1_flag = 1'b0;
    if (!rst) begin
      if (s0_valid && s0_ready) begin
        acc_q.push_back('{id: 1'b0, pix: s0_pixel, contend: s1_valid});
        acc0_flag = 1'b1;
      end
      if (s1_valid && s1_ready) begin
        acc_q.push_back('{id: 1'b1, pix: s1_pixel, contend: s0_valid});
        acc1_flag = 1'b1;
      end
      if (m_valid && m_ready) begin
        out_q.push_back('{id: m_id, mag: m_magnitude, tan: m_tan, neg: m_negative});
        $display("OUT cyc=%0d id=%0d mag=%h tan=%h neg=%0d", cyc, m_id, m_magnitude, m_tan, m_negative);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%0b want=0", m_valid); end
    checks++; if (done0 !== '0 || done1 !== '0) begin errors++; $display("FAIL reset_done got=%0d/%0d want=0/0", done0, done1); end
    checks++; if (m_magnitude !== '0 || m_tan !== '0 || m_negative !== 1'b0 || m_id !== 1'b0) begin
      errors++; $display("FAIL reset_data got=%h/%h/%0b/%0b want=0", m_magnitude, m_tan, m_negative, m_id);
    end
    tick();
    rst = 1'b0;
    model_last = 1'b1; md0 = 0; md1 = 0;
    acc_q.delete(); out_q.delete();
  endtask

  task automatic test_contention();
    acc_t a; out_t o; real err; logic want_id;
    acc_q.delete(); out_q.delete();
    m_ready = 1'b1;
    s0_pixel = rand_pix(); s1_pixel = rand_pix();
    for (int i = 0; i < 6; i++) begin
      if (acc0_flag) s0_pixel = rand_pix();
      if (acc1_flag) s1_pixel = rand_pix();
      s0_valid = 1'b1; s1_valid = 1'b1;
      tick();
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    repeat (4) tick();
    checks++; if (acc_q.size() != 6) begin errors++; $display("FAIL cont_accepts got=%0d want=6", acc_q.size()); end
    for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
      checks++; if (acc_q[i].id !== 1'(i % 2)) begin errors++; $display("FAIL cont_grant%0d got=%0d want=%0d", i, acc_q[i].id, i % 2); end
    end
    checks++; if (out_q.size() != acc_q.size()) begin errors++; $display("FAIL cont_count got=%0d want=%0d", out_q.size(), acc_q.size()); end
    while (out_q.size() > 0 && acc_q.size() > 0) begin
      a = acc_q.pop_front(); o = out_q.pop_front();
      want_id = a.contend ? ~model_last : a.id;
      model_last = a.id;
      checks++; if (a.id !== want_id) begin errors++; $display("FAIL cont_rr got=%0d want=%0d", a.id, want_id); end
      checks++; if (o.id !== a.id) begin errors++; $display("FAIL cont_id got=%0d want=%0d", o.id, a.id); end
      checks++; if (o.tan !== exp_tan(a.pix)) begin errors++; $display("FAIL cont_tan pix=%h got=%h want=%h", a.pix, o.tan, exp_tan(a.pix)); end
      checks++; if (o.neg !== exp_neg(a.pix)) begin errors++; $display("FAIL cont_neg pix=%h got=%0b want=%0b", a.pix, o.neg, exp_neg(a.pix)); end
      err = real'(o.mag) - exp_mag(a.pix);
      checks++; if (err > 1.0 || err < -1.0) begin errors++; $display("FAIL cont_mag pix=%h got=%0d want=%f", a.pix, o.mag, exp_mag(a.pix)); end
      if (a.id) md1 = (md1 + 1) % CNT_M; else md0 = (md0 + 1) % CNT_M;
    end
    acc_q.delete(); out_q.delete();
    @(negedge clk);
    checks++; if (done0 !== CNT_W'(md0) || done0 !== CNT_W'(3)) begin errors++; $display("FAIL cont_done0 got=%0d want=3", done0); end
    checks++; if (done1 !== CNT_W'(md1) || done1 !== CNT_W'(3)) begin errors++; $display("FAIL cont_done1 got=%0d want=3", done1); end
    tick();
  endtask

  task automatic test_single();
    real err;
    logic [31:0] p;
    acc_q.delete(); out_q.delete();
    p = pack(10, 40, 100, 70);
    m_ready = 1'b1; s0_pixel = p; s0_valid = 1'b1; s1_valid = 1'b0;
    @(negedge clk);
    checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%0b want=1", s0_ready); end
    tick();
    s0_valid = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_early got=%0b want=0", m_valid); end
    tick();
    @(negedge clk);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b want=1", m_valid); end
    checks++; if (m_id !== 1'b0) begin errors++; $display("FAIL single_id got=%0b want=0", m_id); end
    checks++; if (m_tan !== 19'h10000 || m_tan !== exp_tan(p)) begin errors++; $display("FAIL single_tan got=%h want=10000", m_tan); end
    checks++; if (m_negative !== exp_neg(p)) begin errors++; $display("FAIL single_neg got=%0b want=%0b", m_negative, exp_neg(p)); end
    err = real'(m_magnitude) - $sqrt(1800.0) * 65536.0;
    checks++; if (err > 1.0 || err < -1.0) begin errors++; $display("FAIL single_mag got=%0d want=%f", m_magnitude, $sqrt(1800.0) * 65536.0); end
    tick();
    md0 = (md0 + 1) % CNT_M; model_last = 1'b0;
    @(negedge clk);
    checks++; if (done0 !== CNT_W'(md0)) begin errors++; $display("FAIL single_done0 got=%0d want=%0d", done0, md0); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%0b want=0", m_valid); end
    tick();
    acc_q.delete(); out_q.delete();
  endtask

  task automatic test_zero_div();
    logic [31:0] p;
    acc_q.delete(); out_q.delete();
    p = pack(5, 5, 9, 9);
    m_ready = 1'b1; s1_pixel = p; s1_valid = 1'b1; s0_valid = 1'b0;
    tick();
    s1_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (m_valid !== 1'b1 || m_id !== 1'b1) begin errors++; $display("FAIL zero_vid got=%0b/%0b want=1/1", m_valid, m_id); end
    checks++; if (m_magnitude !== '0) begin errors++; $display("FAIL zero_mag got=%0d want=0", m_magnitude); end
    checks++; if (m_tan !== exp_tan(p)) begin errors++; $display("FAIL zero_tan got=%h want=%h", m_tan, exp_tan(p)); end
    tick();
    md1 = (md1 + 1) % CNT_M; model_last = 1'b1;
    @(negedge clk);
    checks++; if (done1 !== CNT_W'(md1)) begin errors++; $display("FAIL zero_done1 got=%0d want=%0d", done1, md1); end
    tick();
    acc_q.delete(); out_q.delete();
  endtask

  task automatic test_backpressure();
    acc_t a; out_t o; real err; logic want_id; int idx;
    acc_q.delete(); out_q.delete();
    s0_pixel = rand_pix(); s1_pixel = rand_pix();
    for (int k = 0; k < 14; k++) begin
      if (acc0_flag) s0_pixel = rand_pix();
      if (acc1_flag) s1_pixel = rand_pix();
      s0_valid = 1'b1; s1_valid = 1'b1;
      m_ready = !(k >= 4 && k < 9);
      @(negedge clk);
      if (k >= 4 && k < 9) begin
        idx = out_q.size();
        checks++;
        if (idx >= acc_q.size()) begin
          errors++; $display("FAIL bp_head k=%0d got=%0d want>%0d", k, acc_q.size(), idx);
        end else if (m_valid !== 1'b1 || m_id !== acc_q[idx].id || m_tan !== exp_tan(acc_q[idx].pix)
                     || m_negative !== exp_neg(acc_q[idx].pix)) begin
          errors++; $display("FAIL bp_stable k=%0d got=%0b/%0b/%h want=1/%0b/%h", k, m_valid, m_id, m_tan, acc_q[idx].id, exp_tan(acc_q[idx].pix));
        end
        if (k >= 5) begin
          checks++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready k=%0d got=%0b/%0b want=0/0", k, s0_ready, s1_ready); end
        end
      end
      tick();
    end
    s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b1;
    repeat (4) tick();
    checks++; if (out_q.size() != acc_q.size()) begin errors++; $display("FAIL bp_count got=%0d want=%0d", out_q.size(), acc_q.size()); end
    while (out_q.size() > 0 && acc_q.size() > 0) begin
      a = acc_q.pop_front(); o = out_q.pop_front();
      want_id = a.contend ? ~model_last : a.id;
      model_last = a.id;
      checks++; if (a.id !== want_id) begin errors++; $display("FAIL bp_rr got=%0d want=%0d", a.id, want_id); end
      checks++; if (o.id !== a.id) begin errors++; $display("FAIL bp_id got=%0d want=%0d", o.id, a.id); end
      checks++; if (o.tan !== exp_tan(a.pix)) begin errors++; $display("FAIL bp_tan pix=%h got=%h want=%h", a.pix, o.tan, exp_tan(a.pix)); end
      checks++; if (o.neg !== exp_neg(a.pix)) begin errors++; $display("FAIL bp_neg pix=%h got=%0b want=%0b", a.pix, o.neg, exp_neg(a.pix)); end
      err = real'(o.mag) - exp_mag(a.pix);
      checks++; if (err > 1.0 || err < -1.0) begin errors++; $display("FAIL bp_mag pix=%h got=%0d want=%f", a.pix, o.mag, exp_mag(a.pix)); end
      if (a.id) md1 = (md1 + 1) % CNT_M; else md0 = (md0 + 1) % CNT_M;
    end
    acc_q.delete(); out_q.delete();
    @(negedge clk);
    checks++; if (done0 !== CNT_W'(md0) || done1 !== CNT_W'(md1)) begin errors++; $display("FAIL bp_done got=%0d/%0d want=%0d/%0d", done0, done1, md0, md1); end
    tick();
  endtask

  task automatic test_random();
    acc_t a; out_t o; real err; logic want_id;
    acc_q.delete(); out_q.delete();
    for (int k = 0; k < 300; k++) begin
      if (acc0_flag || !s0_valid) s0_pixel = rand_pix();
      if (acc1_flag || !s1_valid) s1_pixel = rand_pix();
      s0_valid = ($urandom_range(0, 3) != 0);
      s1_valid = ($urandom_range(0, 3) != 0);
      m_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b1;
    repeat (4) tick();
    checks++; if (out_q.size() != acc_q.size()) begin errors++; $display("FAIL rand_count got=%0d want=%0d", out_q.size(), acc_q.size()); end
    while (out_q.size() > 0 && acc_q.size() > 0) begin
      a = acc_q.pop_front(); o = out_q.pop_front();
      want_id = a.contend ? ~model_last : a.id;
      model_last = a.id;
      checks++; if (a.id !== want_id) begin errors++; $display("FAIL rand_rr got=%0d want=%0d", a.id, want_id); end
      checks++; if (o.id !== a.id) begin errors++; $display("FAIL rand_id got=%0d want=%0d", o.id, a.id); end
      checks++; if (o.tan !== exp_tan(a.pix)) begin errors++; $display("FAIL rand_tan pix=%h got=%h want=%h", a.pix, o.tan, exp_tan(a.pix)); end
      checks++; if (o.neg !== exp_neg(a.pix)) begin errors++; $display("FAIL rand_neg pix=%h got=%0b want=%0b", a.pix, o.neg, exp_neg(a.pix)); end
      err = real'(o.mag) - exp_mag(a.pix);
      checks++; if (err > 1.0 || err < -1.0) begin errors++; $display("FAIL rand_mag pix=%h got=%0d want=%f", a.pix, o.mag, exp_mag(a.pix)); end
      if (a.id) md1 = (md1 + 1) % CNT_M; else md0 = (md0 + 1) % CNT_M;
    end
    acc_q.delete(); out_q.delete();
    @(negedge clk);
    checks++; if (done0 !== CNT_W'(md0) || done1 !== CNT_W'(md1)) begin errors++; $display("FAIL rand_done got=%0d/%0d want=%0d/%0d", done0, done1, md0, md1); end
    tick();
  endtask

  task automatic test_mid_reset();
    acc_q.delete(); out_q.delete();
    m_ready = 1'b0;
    s0_pixel = rand_pix(); s1_pixel = rand_pix();
    s0_valid = 1'b1; s1_valid = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++; if (m_valid !== 1'b1 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
      errors++; $display("FAIL mrst_full got=%0b/%0b/%0b want=1/0/0", m_valid, s0_ready, s1_ready);
    end
    tick();
    s0_valid = 1'b0; s1_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got=%0b want=0", m_valid); end
    checks++; if (done0 !== '0 || done1 !== '0) begin errors++; $display("FAIL mrst_done got=%0d/%0d want=0/0", done0, done1); end
    md0 = 0; md1 = 0; model_last = 1'b1;
    acc_q.delete(); out_q.delete();
    tick();
    rst = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mrst_ghost k=%0d got=%0b want=0", k, m_valid); end
      tick();
    end
    s0_valid = 1'b1; s1_valid = 1'b1;
    @(negedge clk);
    checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin errors++; $display("FAIL mrst_grant got=%0b/%0b want=1/0", s0_ready, s1_ready); end
    tick();
    s0_valid = 1'b0; s1_valid = 1'b0;
    repeat (3) tick();
    checks++; if (out_q.size() != 1 || acc_q.size() != 1) begin
      errors++; $display("FAIL mrst_count got=%0d/%0d want=1/1", out_q.size(), acc_q.size());
    end else if (out_q[0].id !== 1'b0) begin
      errors++; $display("FAIL mrst_first_id got=%0b want=0", out_q[0].id);
    end
    md0 = 1; model_last = 1'b0;
    acc_q.delete(); out_q.delete();
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    md0 = 0; md1 = 0; model_last = 1'b1;
    acc_q.delete(); out_q.delete();
    m_ready = 1'b1; s1_valid = 1'b0;
    s0_pixel = rand_pix();
    for (int k = 0; k < 17; k++) begin
      s0_valid = 1'b1;
      tick();
      s0_pixel = rand_pix();
    end
    s0_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    checks++; if (out_q.size() != 17) begin errors++; $display("FAIL wrap_count got=%0d want=17", out_q.size()); end
    checks++; if (done0 !== CNT_W'(17 % CNT_M)) begin errors++; $display("FAIL wrap_done0 got=%0d want=%0d", done0, 17 % CNT_M); end
    checks++; if (done1 !== '0) begin errors++; $display("FAIL wrap_done1 got=%0d want=0", done1); end
    tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_contention();
    test_single();
    test_zero_div();
    test_backpressure();
    test_random();
    test_mid_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
